// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: round-robin digit scan with per-slot
// dead time, leading-zero blanking, and a double-buffered value committed only at frame ends.
module seven_seg_scan_driver #(
    parameter int n_digits      = 4,
    parameter int refresh_limit = 100000,
    parameter int blank_cycles  = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*n_digits-1:0]   value,
    input  logic [n_digits-1:0]     dp_mask,
    input  logic                    load,
    input  logic                    lz_blank,
    output logic                    pending,
    output logic                    frame_done,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [n_digits-1:0]     an
);

    localparam int cnt_w = (refresh_limit > 1) ? $clog2(refresh_limit) : 1;
    localparam int idx_w = $clog2(n_digits);

    localparam logic [cnt_w-1:0] cnt_last  = cnt_w'(refresh_limit - 1);
    localparam logic [cnt_w-1:0] cnt_blank = cnt_w'(blank_cycles);
    localparam logic [idx_w-1:0] idx_last  = idx_w'(n_digits - 1);

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    // Scan position and FSM state (state always describes the current r_count).
    state_t                 r_state;
    logic [cnt_w-1:0]       r_count;
    logic [idx_w-1:0]       r_idx;
    logic                   r_lz;

    // Double buffer: staging is written by load, shadow feeds the display.
    logic [4*n_digits-1:0]  r_stage_val;
    logic [n_digits-1:0]    r_stage_dp;
    logic [4*n_digits-1:0]  r_shadow_val;
    logic [n_digits-1:0]    r_shadow_dp;

    // Registered pins.
    logic [n_digits-1:0]    r_an;
    logic [6:0]             r_seg;
    logic                   r_dp;
    logic                   r_pending;
    logic                   r_frame_done;

    logic                   w_slot_end;
    logic                   w_frame_end;
    logic [cnt_w-1:0]       w_count_next;
    logic [idx_w-1:0]       w_idx_next;
    state_t                 w_state_next;
    logic [3:0]             w_nibble;
    logic                   w_upper_zero;
    logic                   w_lz_digit;
    logic [6:0]             w_seg_drive;
    logic [n_digits-1:0]    w_an_drive;

    // Active-high gfedcba pattern for one hex digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    // NOTE: every signal assigned in this block gets a value on every path, so no latch is inferred.
    always_comb begin
        w_slot_end   = (r_count == cnt_last);
        w_frame_end  = w_slot_end && (r_idx == idx_last);
        w_count_next = w_slot_end ? '0 : r_count + cnt_w'(1);
        w_idx_next   = (r_idx == idx_last) ? '0 : r_idx + idx_w'(1);
        w_state_next = (w_count_next < cnt_blank) ? ST_BLANK : ST_DRIVE;
        w_nibble     = r_shadow_val[{r_idx, 2'b00} +: 4];
        w_upper_zero = ((r_shadow_val >> {r_idx, 2'b00}) == '0);
        w_lz_digit   = r_lz && (r_idx != '0) && w_upper_zero;
        w_seg_drive  = w_lz_digit ? 7'h7F : ~seg_decode(w_nibble);
        w_an_drive   = ~(n_digits'(1) << r_idx);
    end

    // Scan FSM with registered pin outputs; pins reflect the state of the previous cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BLANK;
            r_count      <= '0;
            r_idx        <= '0;
            r_lz         <= 1'b0;
            r_an         <= '1;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_count      <= w_count_next;
            r_state      <= w_state_next;
            r_frame_done <= w_frame_end;
            if (w_slot_end) begin
                r_idx <= w_idx_next;
            end
            // lz_blank is sampled once per slot so a digit cannot change mid-slot.
            if (r_count == '0) begin
                r_lz <= lz_blank;
            end
            case (r_state)
                ST_DRIVE: begin
                    r_an  <= w_an_drive;
                    r_seg <= w_seg_drive;
                    r_dp  <= ~r_shadow_dp[r_idx];
                end
                default: begin
                    r_an  <= '1;
                    r_seg <= 7'h7F;
                    r_dp  <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: non-blocking assignments make a load on the commit cycle hand the old staging
    // contents to shadow while staging captures the new value in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_val  <= '0;
            r_stage_dp   <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (load) begin
                r_stage_val <= value;
                r_stage_dp  <= dp_mask;
            end
            if (w_frame_end) begin
                r_shadow_val <= r_stage_val;
                r_shadow_dp  <= r_stage_dp;
            end
            if (load) begin
                r_pending <= 1'b1;
            end else if (w_frame_end) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign pending    = r_pending;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver: a frame-level model pushes the expected digit
// images per frame; a monitor pops one entry per anode-low run and checks scan timing.
module tb_seven_seg_scan_driver;

    localparam int ND    = 4;
    localparam int RL    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RL;

    logic              clk;
    logic              rst_n;
    logic [4*ND-1:0]   value;
    logic [ND-1:0]     dp_mask;
    logic              load;
    logic              lz_blank;
    logic              pending;
    logic              frame_done;
    logic [6:0]        seg;
    logic              dp;
    logic [ND-1:0]     an;

    seven_seg_scan_driver #(
        .n_digits      (ND),
        .refresh_limit (RL),
        .blank_cycles  (BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp_mask    (dp_mask),
        .load       (load),
        .lz_blank   (lz_blank),
        .pending    (pending),
        .frame_done (frame_done),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    typedef struct packed {
        logic [ND-1:0] an;
        logic [6:0]    seg;
        logic          dp;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_en   = 1'b1;
    logic [6:0]  dec_tab [16];

    // Frame-level reference state.
    logic [15:0] m_stage_v, m_shadow_v;
    logic [3:0]  m_stage_m, m_shadow_m;
    logic        m_pending;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One full frame: push the digits this frame must show, then drive loads cycle by cycle.
    task automatic run_frame(input bit lz, input int lc0, input logic [15:0] lv0, input logic [3:0] lm0,
                             input int lc1, input logic [15:0] lv1, input logic [3:0] lm1,
                             input int abort_c);
        lz_blank = lz;
        for (int i = 0; i < ND; i++) begin
            exp_t e;
            logic [3:0] nib;
            nib   = 4'((m_shadow_v >> (4 * i)) & 16'hF);
            e.an  = ~(ND'(1) << i);
            e.seg = (lz && i > 0 && (m_shadow_v >> (4 * i)) == 16'h0) ? 7'h7F : ~dec_tab[nib];
            e.dp  = ~m_shadow_m[i];
            sb_q.push_back(e);
        end
        for (int c = 0; c < FRAME; c++) begin
            bit ld;
            logic [15:0] vv;
            logic [3:0]  mm;
            ld = 1'b0; vv = '0; mm = '0;
            if (c == lc0) begin ld = 1'b1; vv = lv0; mm = lm0; end
            if (c == lc1) begin ld = 1'b1; vv = lv1; mm = lm1; end
            load = ld;
            if (ld) begin
                value   = vv;
                dp_mask = mm;
            end
            @(posedge clk);
            #1;
            load = 1'b0;
            if (c == FRAME - 1) begin
                m_shadow_v = m_stage_v;
                m_shadow_m = m_stage_m;
            end
            if (ld) begin
                m_stage_v = vv;
                m_stage_m = mm;
                m_pending = 1'b1;
            end else if (c == FRAME - 1) begin
                m_pending = 1'b0;
            end
            check("pending", pending, m_pending);
            if (c == abort_c) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("async_rst_an", an, {ND{1'b1}});
                check("async_rst_seg", seg, 7'h7F);
                check("async_rst_dp", dp, 1'b1);
                check("async_rst_pending", pending, 1'b0);
                @(negedge clk);
                #2;
                rst_n = 1'b1;
                m_stage_v = '0; m_stage_m = '0;
                m_shadow_v = '0; m_shadow_m = '0;
                m_pending = 1'b0;
                return;
            end
        end
    endtask

    // Monitor: one scoreboard pop per anode-low run, plus gap, run-length and frame_done timing.
    initial begin : monitor
        int   cyc;
        int   gap;
        int   run_len;
        bit   in_run;
        bit   run_stable;
        exp_t run_v;
        exp_t e;
        cyc = 0; gap = 0; run_len = 0; in_run = 0; run_stable = 1; run_v = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc = 0; gap = 0; in_run = 0;
                sb_q.delete();
            end else if (mon_en) begin
                cyc++;
                if ((cyc % FRAME == 0) || frame_done)
                    check("frame_done", frame_done, (cyc % FRAME == 0));
                if (an !== {ND{1'b1}}) begin
                    if (!in_run) begin
                        check("blank_gap_before_digit", gap, BC);
                        check("one_anode_low", $countones(~an), 1);
                        check("sb_has_entry", (sb_q.size() != 0), 1);
                        if (sb_q.size() != 0) begin
                            e = sb_q.pop_front();
                            check("an", an, e.an);
                            check("seg", seg, e.seg);
                            check("dp", dp, e.dp);
                        end
                        in_run = 1; run_len = 1; run_stable = 1;
                        run_v = '{an: an, seg: seg, dp: dp};
                    end else begin
                        run_len++;
                        if (an !== run_v.an || seg !== run_v.seg || dp !== run_v.dp) run_stable = 0;
                    end
                    gap = 0;
                end else begin
                    if (in_run) begin
                        check("drive_len", run_len, RL - BC);
                        check("drive_stable", run_stable, 1);
                        in_run = 0;
                    end
                    gap++;
                    check("blank_seg_dp", {seg, dp}, 8'hFF);
                end
            end
        end
    end

    initial begin : stimulus
        dec_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        rst_n = 1'b0; value = '0; dp_mask = '0; load = 1'b0; lz_blank = 1'b0;
        m_stage_v = '0; m_stage_m = '0; m_shadow_v = '0; m_shadow_m = '0; m_pending = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an", an, {ND{1'b1}});
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_pending", pending, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        #2;
        rst_n = 1'b1;

        // Idle frame shows "0000"; then a mid-frame load and its commit.
        run_frame(1'b0, -1, '0, '0, -1, '0, '0, -1);
        run_frame(1'b0, 13, 16'h12AF, 4'b0100, -1, '0, '0, -1);
        // Leading-zero blanking of 0050, then of 0000.
        run_frame(1'b1, 5, 16'h0050, 4'b0000, -1, '0, '0, -1);
        run_frame(1'b1, 20, 16'h0000, 4'b0000, -1, '0, '0, -1);
        // Load on the exact commit cycle: 1234 shows first, BEEF one frame later.
        run_frame(1'b1, 10, 16'h1234, 4'b0000, FRAME - 1, 16'hBEEF, 4'b1001, -1);
        run_frame(1'b0, -1, '0, '0, -1, '0, '0, -1);
        // Reset during digit 2 DRIVE drops the pending staging.
        run_frame(1'b0, 4, 16'h5678, 4'b1111, -1, '0, '0, 2 * RL + BC + 1);

        for (int f = 0; f < 10; f++) begin
            int lc0, lc1;
            logic [15:0] v0, v1;
            lc0 = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, FRAME - 1));
            lc1 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, FRAME - 1)) : -1;
            v0  = 16'($urandom) >> (4 * $urandom_range(0, 4));
            v1  = 16'($urandom) >> (4 * $urandom_range(0, 4));
            run_frame(1'($urandom_range(0, 1)), lc0, v0, 4'($urandom), lc1, v1, 4'($urandom), -1);
        end

        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
